// File: rtl/rf_wb_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths,
// source identifiers carried on wb_src, and the conflict counter width.
// No logic; imported by the arbiter top and its grant sub-module.
package rf_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W      = 16;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic for the writeback port; round-robin via a last-winner pointer,
// or fixed A-over-B priority when WB_ARB_FIXED_PRIO_EN is defined (pointer removed).
// Latency: grants are combinational; pointer updates on the accepting edge. Stall or reset drops both grants.
module rr_arb2
  import rf_wb_pkg::*;
(
`ifndef WB_ARB_FIXED_PRIO_EN
  input  logic i_clk,
`endif
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_stall,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic w_open;
  assign w_open = i_rst_n & ~i_stall;

`ifdef WB_ARB_FIXED_PRIO_EN

  // A always wins; B only gets the port when A is idle.
  always_comb begin
    o_gnt_a = w_open & i_req_a;
    o_gnt_b = w_open & i_req_b & ~i_req_a;
  end

`else

  // Source granted most recently; reset to B so A wins the first conflict.
  logic r_last;

  // On a conflict the pointer picks the side that did not win last time.
  always_comb begin
    o_gnt_a = w_open & i_req_a & (~i_req_b | (r_last == SRC_B));
    o_gnt_b = w_open & i_req_b & (~i_req_a | (r_last == SRC_A));
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= SRC_B;
    end else if (o_gnt_a) begin
      r_last <= SRC_A;
    end else if (o_gnt_b) begin
      r_last <= SRC_B;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load-unit (B) writebacks onto one register-file write port.
// Latency: 1 cycle from accept to wb_en; writes to x0 are consumed but never issued.
// Backpressure: wb_stall drops both readies and freezes the write port. Option macro: WB_ARB_FIXED_PRIO_EN.
module regfile_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wb_stall,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_src;

  logic              r_wb_en;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_src;
  logic [CNT_W-1:0]  r_conflict_cnt;

  rr_arb2 u_arb (
`ifndef WB_ARB_FIXED_PRIO_EN
    .i_clk   (clk),
`endif
    .i_rst_n (rst_n),
    .i_req_a (a_valid),
    .i_req_b (b_valid),
    .i_stall (wb_stall),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign a_ready  = w_gnt_a;
  assign b_ready  = w_gnt_b;
  assign w_accept = w_gnt_a | w_gnt_b;

  // Mux the granted request onto the write-port inputs.
  always_comb begin
    w_sel_addr = a_addr;
    w_sel_data = a_data;
    w_sel_src  = SRC_A;
    if (w_gnt_b) begin
      w_sel_addr = b_addr;
      w_sel_data = b_data;
      w_sel_src  = SRC_B;
    end
  end

  // Write port: load on accept, drop wb_en when idle, freeze everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_src  <= SRC_A;
    end else if (!wb_stall) begin
      r_wb_en <= w_accept & (w_sel_addr != '0);
      if (w_accept) begin
        r_wb_addr <= w_sel_addr;
        r_wb_data <= w_sel_data;
        r_wb_src  <= w_sel_src;
      end
    end
  end

  // Saturating count of cycles where both sides request, stalled or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (a_valid && b_valid && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign wb_en        = r_wb_en;
  assign wb_addr      = r_wb_addr;
  assign wb_data      = r_wb_data;
  assign wb_src       = r_wb_src;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single grants, round-robin conflicts,
// x0 writes, stall hold, mid-transfer reset, and fixed priority when WB_ARB_FIXED_PRIO_EN is set.
// Inputs change 1ns after a rising edge; outputs are sampled 1-2ns after the edge.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, wb_stall;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          wb_en, wb_src;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [15:0]   conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .wb_stall     (wb_stall),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_src       (wb_src),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; wb_stall = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    tick();

    // Reset state, with A requesting to show ready is held low.
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; b_valid = 1'b1; b_addr = 5'd4;
    #1;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("rst_wb_en",   32'(wb_en), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_src",  32'(wb_src), 32'd0);
    chk("rst_cnt",     32'(conflict_cnt), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("post_rst_wb_en", 32'(wb_en), 32'd0);

`ifndef WB_ARB_FIXED_PRIO_EN
    // Single A request: same-cycle ready, write one cycle later.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    #1;
    chk("s1_a_ready", 32'(a_ready), 32'd1);
    chk("s1_b_ready", 32'(b_ready), 32'd0);
    tick();
    idle();
    chk("s1_wb_en",   32'(wb_en), 32'd1);
    chk("s1_wb_addr", 32'(wb_addr), 32'd5);
    chk("s1_wb_data", wb_data, 32'h1234);
    chk("s1_wb_src",  32'(wb_src), 32'd0);
    tick();
    chk("s1_idle_wb_en", 32'(wb_en), 32'd0);

    // Four-cycle conflict from a fresh pointer: A,B,A,B.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("s2_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("s2_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("s2_wb_en",   32'(wb_en), 32'd1);
      chk("s2_wb_src",  32'(wb_src), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("s2_wb_addr", 32'(wb_addr), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("s2_wb_data", wb_data, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    idle();
    chk("s2_cnt", 32'(conflict_cnt), 32'd4);

    // A accept leaves the pointer at A; a B write to x0 must still move it to B.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    tick();
    idle();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hDEAD;
    #1;
    chk("s3_b_ready", 32'(b_ready), 32'd1);
    tick();
    idle();
    chk("s3_x0_wb_en", 32'(wb_en), 32'd0);
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
    #1;
    chk("s3_conf_a_ready", 32'(a_ready), 32'd1);
    chk("s3_conf_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("s3_wb_addr", 32'(wb_addr), 32'd6);
    chk("s3_wb_src",  32'(wb_src), 32'd0);
    chk("s3_cnt",     32'(conflict_cnt), 32'd5);

    // Stall three cycles with both valid: no grants, port frozen, counter still runs.
    a_addr = 5'd9;  a_data = 32'h99;
    b_addr = 5'd10; b_data = 32'hAA;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s4_stall_a_ready", 32'(a_ready), 32'd0);
      chk("s4_stall_b_ready", 32'(b_ready), 32'd0);
      tick();
      chk("s4_hold_wb_en",   32'(wb_en), 32'd1);
      chk("s4_hold_wb_addr", 32'(wb_addr), 32'd6);
      chk("s4_hold_wb_data", wb_data, 32'h66);
    end
    chk("s4_stall_cnt", 32'(conflict_cnt), 32'd8);
    wb_stall = 1'b0;
    #1;
    chk("s4_rel_b_ready", 32'(b_ready), 32'd1);
    chk("s4_rel_a_ready", 32'(a_ready), 32'd0);
    tick();
    idle();
    chk("s4_rel_wb_src",  32'(wb_src), 32'd1);
    chk("s4_rel_wb_addr", 32'(wb_addr), 32'd10);
    chk("s4_rel_cnt",     32'(conflict_cnt), 32'd9);

    // Reset right after accepting A->x7 discards the write.
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("s5_rst_wb_en",   32'(wb_en), 32'd0);
    chk("s5_rst_cnt",     32'(conflict_cnt), 32'd0);
    chk("s5_rst_wb_addr", 32'(wb_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s5_after_wb_en",   32'(wb_en), 32'd0);
    chk("s5_after_wb_addr", 32'(wb_addr), 32'd0);
    tick();
    chk("s5_later_wb_en", 32'(wb_en), 32'd0);
`else
    // Fixed priority: A wins every conflict, B never ready.
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_a_ready", 32'(a_ready), 32'd1);
      chk("fp_b_ready", 32'(b_ready), 32'd0);
      tick();
      chk("fp_wb_src",  32'(wb_src), 32'd0);
      chk("fp_wb_addr", 32'(wb_addr), 32'd1);
    end
    idle();
    chk("fp_cnt", 32'(conflict_cnt), 32'd3);
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    #1;
    chk("fp_b_alone_ready", 32'(b_ready), 32'd1);
    tick();
    idle();
    chk("fp_b_wb_src", 32'(wb_src), 32'd1);
    chk("fp_b_wb_addr", 32'(wb_addr), 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
